// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target with pointer-addressed register file and local port
// Pins are synchronised and glitch-filtered; every bus event is derived from the filtered edges.
module i2c_slave_regs #(
  parameter logic [6:0] ADDR   = 7'h42,
  parameter int         ADDR_W = 3,
  parameter int         FILT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic              loc_we,
  input  logic [7:0]        loc_wdata,
  output logic [7:0]        loc_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy
);
  localparam int NREG = 1 << ADDR_W;
  localparam int FW   = (FILT > 1) ? $clog2(FILT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync1_q, sync2_q, filt_q, filt_prev_q;  // bit 0 = SCL, bit 1 = SDA
  logic [FW-1:0]     fcnt_q [2];
  logic [7:0]        regs_q [NREG];
  logic [7:0]        sr_q, sr_d, rx_byte;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic              sda_oe_q, sda_oe_d, busy_q, busy_d, rw_q, rw_d, wr_strobe_q;
  logic              i2c_we, load_rd;
  logic              scl_rise, scl_fall, start_det, stop_det, last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      filt_q      <= '1;
      filt_prev_q <= '1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q     <= {sda_in, scl};
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILT - 1)) begin
          fcnt_q[i] <= '0;
          filt_q[i] <= sync2_q[i];
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign scl_rise  = filt_q[0] & ~filt_prev_q[0];
  assign scl_fall  = ~filt_q[0] & filt_prev_q[0];
  assign start_det = filt_q[0] & filt_prev_q[0] & filt_prev_q[1] & ~filt_q[1];
  assign stop_det  = filt_q[0] & filt_prev_q[0] & ~filt_prev_q[1] & filt_q[1];
  assign rx_byte   = {sr_q[6:0], filt_q[1]};
  assign last_bit  = scl_rise && (cnt_q == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // In the ACK states and RACK, cnt_q[0] marks that the first SCL fall has been seen.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = S_IDLE;
    end else if (start_det) begin
      state_d = S_ADDR;
    end else begin
      case (state_q)
        S_ADDR:      if (last_bit) state_d = (rx_byte[7:1] == ADDR) ? S_ADDR_ACK : S_WAIT;
        S_PTR:       if (last_bit) state_d = S_PTR_ACK;
        S_WDATA:     if (last_bit) state_d = S_WDATA_ACK;
        S_ADDR_ACK:  if (scl_fall && cnt_q[0]) state_d = rw_q ? S_RDATA : S_PTR;
        S_PTR_ACK,
        S_WDATA_ACK: if (scl_fall && cnt_q[0]) state_d = S_WDATA;
        S_RDATA:     if (last_bit) state_d = S_RACK;
        S_RACK: begin
          if (scl_rise && filt_q[1])         state_d = S_WAIT;
          else if (scl_fall && cnt_q[0])     state_d = S_RDATA;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    wr_addr_d = wr_addr_q;
    i2c_we    = 1'b0;
    load_rd   = 1'b0;
    if (stop_det || start_det) begin
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: if (scl_rise) begin
          sr_d  = rx_byte;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (state_q == S_ADDR) begin
              rw_d   = rx_byte[0];
              busy_d = (rx_byte[7:1] == ADDR);
            end
            if (state_q == S_PTR) ptr_d = rx_byte[ADDR_W-1:0];
            if (state_q == S_WDATA) begin
              i2c_we    = 1'b1;
              wr_addr_d = ptr_q;
              ptr_d     = ptr_q + 1'b1;
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
          if (!cnt_q[0]) begin
            sda_oe_d = 1'b1;
            cnt_d    = 3'd1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            load_rd  = (state_q == S_ADDR_ACK) && rw_q;
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            sda_oe_d = ~sr_q[7];
            sr_d     = {sr_q[6:0], 1'b0};
          end
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) ptr_d = ptr_q + 1'b1;
          end
        end
        S_RACK: begin
          if (scl_fall) begin
            if (!cnt_q[0]) begin
              sda_oe_d = 1'b0;
            end else begin
              cnt_d   = '0;
              load_rd = 1'b1;
            end
          end
          if (scl_rise && !filt_q[1]) cnt_d = 3'd1;
        end
        default: ;
      endcase
    end
    // Snapshot the whole byte at the fall that starts it; bit 7 goes out immediately.
    if (load_rd) begin
      sda_oe_d = ~regs_q[ptr_q][7];
      sr_d     = {regs_q[ptr_q][6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      sr_q        <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      wr_strobe_q <= i2c_we;
      wr_addr_q   <= wr_addr_d;
      for (int i = 0; i < NREG; i++) begin
        if (i2c_we && ptr_q == ADDR_W'(i))          regs_q[i] <= rx_byte;
        else if (loc_we && loc_addr == ADDR_W'(i))  regs_q[i] <= loc_wdata;
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign loc_rdata = regs_q[loc_addr];

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - directed-vector bench for i2c_slave_regs
// Drives an open-drain bus master model; expected register contents are tracked in exp_regs.
module tb_i2c_slave_regs;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst, scl, sda_in, sda_oe, loc_we, wr_strobe, busy;
  logic [2:0] loc_addr, wr_addr;
  logic [7:0] loc_wdata, loc_rdata;
  logic       m_scl, m_sda, glitch, g_en;
  int         vecs = 0, errs = 0;
  int         ns = 0, oe_cnt = 0, busy_cnt = 0;
  logic [2:0] sa [16];
  logic [7:0] exp_regs [8];

  always #5 clk = ~clk;
  assign scl    = m_scl | glitch;
  assign sda_in = m_sda & ~sda_oe;

  i2c_slave_regs #(.ADDR(7'h42), .ADDR_W(3), .FILT(3)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .loc_addr(loc_addr), .loc_we(loc_we), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_strobe) begin
      if (ns < 16) sa[ns] = wr_addr;
      ns++;
    end
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clk_bit(input logic b, output logic line);
    m_sda = b;
    if (g_en) begin
      wclk(Q / 2); glitch = 1'b1; wclk(1); glitch = 1'b0; wclk(Q / 2 - 1);
    end else begin
      wclk(Q);
    end
    m_scl = 1'b1; wclk(Q);
    line = sda_in; wclk(Q);
    m_scl = 1'b0; wclk(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wclk(Q); m_scl = 1'b1; wclk(Q); m_sda = 1'b0; wclk(Q); m_scl = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wclk(Q); m_scl = 1'b1; wclk(Q); m_sda = 1'b1; wclk(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], l);
    clk_bit(1'b1, l);
    ack = ~l;
  endtask

  task automatic recv_byte(input logic nack, input logic poke, output logic [7:0] d,
                           output logic ack_line);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, l);
      d[i] = l;
      if (poke && i == 4) begin
        loc_addr = 3'd6; loc_wdata = 8'h00; loc_we = 1'b1; wclk(1); loc_we = 1'b0;
      end
    end
    clk_bit(nack, ack_line);
  endtask

  task automatic loc_write(input logic [2:0] a, input logic [7:0] d);
    loc_addr = a; loc_wdata = d; loc_we = 1'b1; wclk(1); loc_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; glitch = 1'b0; g_en = 1'b0;
    loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    wclk(3); rst = 1'b0; wclk(10);
    vecs++; if (sda_oe !== 1'b0) begin errs++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vecs++; if (wr_strobe !== 1'b0) begin errs++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
    vecs++; if (wr_addr !== 3'd0) begin errs++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    for (int i = 0; i < 8; i++) begin
      loc_addr = 3'(i); #1;
      vecs++; if (loc_rdata !== 8'h00) begin errs++; $display("FAIL reset_reg%0d: got %h want 00", i, loc_rdata); end
    end
  endtask

  task automatic test_write();
    logic [3:0] acks;
    int s0;
    s0 = ns;
    i2c_start();
    send_byte(8'h84, acks[3]);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL write_busy_set: got %b want 1", busy); end
    send_byte(8'h02, acks[2]);
    send_byte(8'hA5, acks[1]);
    send_byte(8'h5A, acks[0]);
    i2c_stop();
    exp_regs[2] = 8'hA5; exp_regs[3] = 8'h5A;
    vecs++; if (acks !== 4'b1111) begin errs++; $display("FAIL write_acks: got %b want 1111", acks); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL write_busy_clear: got %b want 0", busy); end
    vecs++; if (ns - s0 !== 2) begin errs++; $display("FAIL write_strobes: got %0d want 2", ns - s0); end
    vecs++; if (sa[s0] !== 3'd2) begin errs++; $display("FAIL write_addr0: got %0d want 2", sa[s0]); end
    vecs++; if (sa[s0+1] !== 3'd3) begin errs++; $display("FAIL write_addr1: got %0d want 3", sa[s0+1]); end
    loc_addr = 3'd2; #1;
    vecs++; if (loc_rdata !== 8'hA5) begin errs++; $display("FAIL write_reg2: got %h want a5", loc_rdata); end
    loc_addr = 3'd3; #1;
    vecs++; if (loc_rdata !== 8'h5A) begin errs++; $display("FAIL write_reg3: got %h want 5a", loc_rdata); end
  endtask

  task automatic test_wrap();
    logic [3:0] acks;
    int s0;
    s0 = ns;
    i2c_start();
    send_byte(8'h84, acks[3]);
    send_byte(8'h07, acks[2]);
    send_byte(8'h11, acks[1]);
    send_byte(8'h22, acks[0]);
    i2c_stop();
    exp_regs[7] = 8'h11; exp_regs[0] = 8'h22;
    vecs++; if (acks !== 4'b1111) begin errs++; $display("FAIL wrap_acks: got %b want 1111", acks); end
    vecs++; if (sa[s0] !== 3'd7 || sa[s0+1] !== 3'd0) begin
      errs++; $display("FAIL wrap_addrs: got %0d,%0d want 7,0", sa[s0], sa[s0+1]);
    end
    loc_addr = 3'd7; #1;
    vecs++; if (loc_rdata !== 8'h11) begin errs++; $display("FAIL wrap_reg7: got %h want 11", loc_rdata); end
    loc_addr = 3'd0; #1;
    vecs++; if (loc_rdata !== 8'h22) begin errs++; $display("FAIL wrap_reg0: got %h want 22", loc_rdata); end
  endtask

  task automatic test_ptr_persist();
    logic ak, nl;
    logic [7:0] d;
    loc_write(3'd1, 8'h3C);
    exp_regs[1] = 8'h3C;
    i2c_start();
    send_byte(8'h85, ak);
    recv_byte(1'b1, 1'b0, d, nl);
    i2c_stop();
    vecs++; if (ak !== 1'b1) begin errs++; $display("FAIL persist_ack: got %b want 1", ak); end
    vecs++; if (d !== 8'h3C) begin errs++; $display("FAIL persist_data: got %h want 3c", d); end
  endtask

  task automatic test_rstart_read();
    logic [2:0] acks;
    logic [7:0] d0, d1, d2;
    logic nl0, nl1, nl2;
    int o0;
    loc_write(3'd6, 8'h96);
    i2c_start();
    send_byte(8'h84, acks[2]);
    send_byte(8'h06, acks[1]);
    i2c_start();
    send_byte(8'h85, acks[0]);
    recv_byte(1'b0, 1'b1, d0, nl0);
    exp_regs[6] = 8'h00;
    recv_byte(1'b0, 1'b0, d1, nl1);
    recv_byte(1'b1, 1'b0, d2, nl2);
    o0 = oe_cnt;
    i2c_stop();
    vecs++; if (acks !== 3'b111) begin errs++; $display("FAIL rd_acks: got %b want 111", acks); end
    vecs++; if (d0 !== 8'h96) begin errs++; $display("FAIL rd_byte0_snapshot: got %h want 96", d0); end
    vecs++; if (d1 !== 8'h11) begin errs++; $display("FAIL rd_byte1: got %h want 11", d1); end
    vecs++; if (d2 !== 8'h22) begin errs++; $display("FAIL rd_byte2_wrap: got %h want 22", d2); end
    vecs++; if (nl2 !== 1'b1) begin errs++; $display("FAIL rd_nack_released: got %b want 1", nl2); end
    vecs++; if (oe_cnt != o0) begin errs++; $display("FAIL rd_drive_after_nack: got %0d want 0", oe_cnt - o0); end
    loc_addr = 3'd6; #1;
    vecs++; if (loc_rdata !== 8'h00) begin errs++; $display("FAIL rd_local_write: got %h want 00", loc_rdata); end
  endtask

  task automatic test_mismatch();
    logic [1:0] nacks;
    logic [2:0] acks;
    int o0, b0, s0;
    o0 = oe_cnt; b0 = busy_cnt; s0 = ns;
    i2c_start();
    send_byte(8'h86, nacks[1]);
    send_byte(8'h77, nacks[0]);
    i2c_stop();
    vecs++; if (nacks !== 2'b00) begin errs++; $display("FAIL mm_ack: got %b want 00", nacks); end
    vecs++; if (oe_cnt != o0) begin errs++; $display("FAIL mm_sda_oe: got %0d drive cycles want 0", oe_cnt - o0); end
    vecs++; if (busy_cnt != b0) begin errs++; $display("FAIL mm_busy: got %0d busy cycles want 0", busy_cnt - b0); end
    vecs++; if (ns != s0) begin errs++; $display("FAIL mm_strobe: got %0d want 0", ns - s0); end
    for (int i = 0; i < 8; i++) begin
      loc_addr = 3'(i); #1;
      vecs++; if (loc_rdata !== exp_regs[i]) begin
        errs++; $display("FAIL mm_reg%0d: got %h want %h", i, loc_rdata, exp_regs[i]);
      end
    end
    i2c_start();
    send_byte(8'h84, acks[2]);
    send_byte(8'h05, acks[1]);
    send_byte(8'h99, acks[0]);
    i2c_stop();
    exp_regs[5] = 8'h99;
    vecs++; if (acks !== 3'b111) begin errs++; $display("FAIL mm_after_acks: got %b want 111", acks); end
    loc_addr = 3'd5; #1;
    vecs++; if (loc_rdata !== 8'h99) begin errs++; $display("FAIL mm_after_reg5: got %h want 99", loc_rdata); end
  endtask

  task automatic test_glitch();
    logic [2:0] acks;
    int s0;
    i2c_start();
    send_byte(8'h84, acks[2]);
    send_byte(8'h04, acks[1]);
    s0 = ns;
    g_en = 1'b1;
    send_byte(8'hC3, acks[0]);
    g_en = 1'b0;
    i2c_stop();
    exp_regs[4] = 8'hC3;
    vecs++; if (acks !== 3'b111) begin errs++; $display("FAIL glitch_acks: got %b want 111", acks); end
    vecs++; if (ns - s0 !== 1 || sa[s0] !== 3'd4) begin
      errs++; $display("FAIL glitch_strobe: got %0d pulses addr %0d want 1 addr 4", ns - s0, sa[s0]);
    end
    loc_addr = 3'd4; #1;
    vecs++; if (loc_rdata !== 8'hC3) begin errs++; $display("FAIL glitch_reg4: got %h want c3", loc_rdata); end
  endtask

  task automatic test_reset_mid_read();
    logic ak, l;
    i2c_start();
    send_byte(8'h85, ak);
    clk_bit(1'b1, l);
    vecs++; if (l !== 1'b1) begin errs++; $display("FAIL rst_rd_bit7: got %b want 1", l); end
    vecs++; if (sda_oe !== 1'b1) begin errs++; $display("FAIL rst_rd_drive_bit6: got %b want 1", sda_oe); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    vecs++; if (sda_oe !== 1'b0) begin errs++; $display("FAIL rst_async_release: got %b want 0", sda_oe); end
    m_scl = 1'b1; m_sda = 1'b1;
    wclk(3); rst = 1'b0; wclk(10);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    for (int i = 0; i < 8; i++) begin
      loc_addr = 3'(i); #1;
      vecs++; if (loc_rdata !== 8'h00) begin errs++; $display("FAIL rst_reg%0d: got %h want 00", i, loc_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrap();
    test_ptr_persist();
    test_rstart_read();
    test_mismatch();
    test_glitch();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
